xor_sweep_checker: RTL
======================

# xor_sweep_checker

Self-checking exhaustive stimulus engine for N-input XOR/XNOR gates. It is the parametrised successor of the fixed 2-bit lab counter. On a start pulse it drives every input pattern 0 … 2^WIDTH−1 onto the gate under test and waits a programmable settle time per pattern. It compares the gate output against internally computed parity, then reports pass/fail, an error count and the first failing pattern. It sits in the lab harness between the stimulus side and the device under test, and it is synthesizable so the same sweep runs on the board.

## Interface
- WIDTH, 2, number of gate inputs (stim width), 1..16
- SETTLE, 1, extra cycles each pattern is held before sampling, 0..255
- INVERT, 0, 0 = expect XOR (odd parity), 1 = expect XNOR
- ERR_W, 8, width of error counter

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  sweep request, sampled only in IDLE
- dut_out  in  1  output of gate under test
- stim  out  WIDTH  pattern applied to gate under test
- busy  out  1  high while sweep in progress
- done  out  1  one-cycle pulse after last pattern sampled
- pass  out  1  1 when last completed sweep had zero errors; held until next start
- err_count  out  ERR_W  mismatches in current/last sweep, saturating
- fail_valid  out  1  at least one mismatch recorded
- first_fail  out  WIDTH  pattern of first mismatch, valid when fail_valid

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0. On start=1, the next state is RUN, with stim=0, settle counter=0, err_count=0, fail_valid=0, first_fail=0, pass=0.
- RUN: busy=1. Each edge:
  - if settle counter < SETTLE, increment it;
  - otherwise sample dut_out against expected = (^stim) ^ INVERT;
  - on mismatch, err_count increments, saturating at 2^ERR_W−1;
  - on the first mismatch of the sweep, first_fail=stim and fail_valid=1;
  - then the settle counter clears;
  - if stim = all ones, go to DONE (stim holds its value), else stim+1.
- DONE: done=1 and busy=0 for exactly one cycle. pass=(err_count==0 and fail_valid==0) is registered on entry to DONE. The next state is IDLE.
- start is ignored in RUN and DONE, with no queuing.
- stim never wraps within a sweep and holds all ones in IDLE after a sweep until the next start.
- Results (pass, err_count, fail_valid, first_fail) hold through IDLE until the next accepted start clears them.
- Saturation: err_count stops at max. Mismatches after saturation still do not alter first_fail.

## Timing
- All outputs reset to 0 asynchronously when rst_n=0; state is IDLE. Reset mid-sweep aborts immediately with no done pulse.
- Deassertion of rst_n is synchronized externally. The block acts on the first edge with rst_n=1.
- Start accepted at edge E0 → stim=0 and busy=1 from E0.
- Each pattern is held SETTLE+1 cycles. dut_out is sampled at the edge ending the pattern's window, so it must be stable SETTLE+1 cycles after stim changes.
- Busy duration = 2^WIDTH × (SETTLE+1) cycles. done is high in the following cycle. The earliest next start is accepted one cycle after done.
- Timing examples:
  - WIDTH=2, SETTLE=1: busy for 8 cycles, done at cycle 9 after E0.
  - SETTLE=0: one pattern per cycle, dut_out sampled in the same cycle stim is valid, so it must be combinational.

## Test plan
- WIDTH=2, SETTLE=1, INVERT=0, dut_out=^stim (combinational) → stim steps 0,1,2,3, each for 2 cycles. done pulses once 9 cycles after start; pass=1, err_count=0, fail_valid=0.
- Same, dut_out tied 0 → mismatches at stim 1 and 2. Result: err_count=2, first_fail=2'b01, fail_valid=1, pass=0.
- INVERT=1 with XOR gate under test → err_count=4, first_fail=0, pass=0. Replace with an XNOR gate → pass=1.
- WIDTH=4, ERR_W=2, SETTLE=0, dut_out=0 → 8 real mismatches, err_count saturates at 3, first_fail=4'b0001. done is 17 cycles after start.
- start pulsed repeatedly during RUN → sweep and results unchanged. A second accepted start after done clears err_count/fail_valid/pass and restarts from stim=0.
- rst_n pulsed low at mid-sweep (stim=2) → all outputs 0 immediately with no done. A following start runs a full clean sweep from 0.

Source files
------------

// File: rtl/xor_sweep_checker.sv
// rtl/xor_sweep_checker.sv - exhaustive XOR/XNOR gate sweep engine with parity self-check
module xor_sweep_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int INVERT = 0,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_out,
  output logic [WIDTH-1:0] stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] first_fail
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic       INV_BIT    = (INVERT != 0);
  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] stim_q, stim_d;
  logic [7:0]       settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0] first_fail_q, first_fail_d;
  logic             pass_q, pass_d;

  logic settle_done;
  logic last_pattern;
  logic mismatch;

  assign settle_done  = (settle_q == SETTLE_MAX);
  assign last_pattern = &stim_q;
  assign mismatch     = dut_out != ((^stim_q) ^ INV_BIT);

  // State and datapath registers; reset clears every result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      stim_q       <= '0;
      settle_q     <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stim_q       <= stim_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  // Next-state: a sweep ends on the sampling edge of the all-ones pattern.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (settle_done && last_pattern) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: clear on accepted start, step/sample while running.
  always_comb begin
    stim_d       = stim_q;
    settle_d     = settle_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          stim_d       = '0;
          settle_d     = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
          pass_d       = 1'b0;
        end
      end
      RUN: begin
        if (!settle_done) begin
          settle_d = settle_q + 8'd1;
        end else begin
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              first_fail_d = stim_q;
            end
          end
          settle_d = '0;
          // The final pattern's own sample must count toward the verdict.
          if (last_pattern) pass_d = (err_d == '0) && !fail_valid_d;
          else              stim_d = stim_q + WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs: status decoded from state, results straight from registers.
  always_comb begin
    busy       = (state_q == RUN);
    done       = (state_q == DONE);
    stim       = stim_q;
    pass       = pass_q;
    err_count  = err_q;
    fail_valid = fail_valid_q;
    first_fail = first_fail_q;
  end

endmodule
